// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, frame geometry
// and the word-count validity rule.
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // A frame is usable only if it carries at least one word and fits the store.
  function automatic logic count_ok(input logic [8*HDR_BYTES-1:0] n,
                                    input int max_words);
    return (n != '0) && (int'(n) <= max_words);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
//
// Handshake: a byte transfers on a rising clk edge exactly when rx_valid and
// rx_ready are both high in the preceding cycle; rx_data must be stable while
// rx_valid is high, and rx_ready never depends on rx_valid.
interface program_loader_if #(
  parameter int ADDR_W = 11
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Collects bytes MSB-first into a 32-bit word; word_next is the word that
// would be complete if the current byte is taken while last_byte is high.
module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic [31:0] word_next
);

  localparam int IDX_W   = $clog2(BYTES_PER_WORD);
  localparam int SHIFT_W = 8 * (BYTES_PER_WORD - 1);

  logic [SHIFT_W-1:0] shift_q;
  logic [IDX_W-1:0]   byte_idx_q;

  // Only the first three bytes need storage; the fourth is used straight
  // from the input in the same cycle it is accepted.
  assign word_next = {shift_q, byte_in};
  assign last_byte = (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else if (clear) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else if (byte_en) begin
      shift_q    <= word_next[SHIFT_W-1:0];
      byte_idx_q <= byte_idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Writer side of the instruction store: unpacks a length-prefixed byte frame
// into 32-bit words written sequentially from address 0.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  program_loader_if.master  bus,
  output logic              load_active,
  output logic              done,
  output logic              err_len,
  output logic [ADDR_W:0]   words_written,
  output state_t            dbg_state
);

  localparam int CW = ADDR_W + 1;

  state_t                 state_q;
  state_t                 state_d;
  logic                   rx_ready;
  logic                   mem_we;
  logic                   accept;
  logic                   pack_en;
  logic                   pack_clear;
  logic                   last_byte;
  logic [31:0]            word_next;
  logic [7:0]             cnt_hi_q;
  logic [8*HDR_BYTES-1:0] hdr_n;
  logic                   len_ok;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          word_idx_q;
  logic                   last_word;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [31:0]            mem_wdata_q;

  assign accept     = bus.rx_valid && rx_ready;
  assign pack_en    = accept && (state_q == S_DATA);
  assign pack_clear = (state_q == S_IDLE) && start;
  assign hdr_n      = {cnt_hi_q, bus.rx_data};
  assign len_ok     = count_ok(hdr_n, MAX_WORDS);
  assign last_word  = ((word_idx_q + CW'(1)) == count_q);

  assign bus.rx_ready  = rx_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state     = state_q;

  program_loader_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pack_clear),
    .byte_en   (pack_en),
    .byte_in   (bus.rx_data),
    .last_byte (last_byte),
    .word_next (word_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // rx_ready is a function of state alone, so the DATA transition tests
  // rx_valid directly to keep the handshake free of combinational loops.
  always_comb begin
    state_d     = state_q;
    rx_ready    = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;
    load_active = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CNT_HI;
      end
      S_CNT_HI: begin
        rx_ready    = 1'b1;
        load_active = 1'b1;
        if (bus.rx_valid) state_d = S_CNT_LO;
      end
      S_CNT_LO: begin
        rx_ready    = 1'b1;
        load_active = 1'b1;
        if (bus.rx_valid) state_d = len_ok ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        rx_ready    = 1'b1;
        load_active = 1'b1;
        if (bus.rx_valid && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_we      = 1'b1;
        load_active = 1'b1;
        state_d     = last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // mem_addr/mem_wdata are captured with the fourth byte so they are valid
  // throughout WRITE and keep the last written value afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_len       <= 1'b0;
      words_written <= '0;
      cnt_hi_q      <= '0;
      count_q       <= '0;
      word_idx_q    <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_len       <= 1'b0;
            words_written <= '0;
            word_idx_q    <= '0;
            count_q       <= '0;
          end
        end
        S_CNT_HI: begin
          if (accept) cnt_hi_q <= bus.rx_data;
        end
        S_CNT_LO: begin
          if (accept) begin
            if (len_ok) count_q <= hdr_n[CW-1:0];
            else        err_len <= 1'b1;
          end
        end
        S_DATA: begin
          if (pack_en && last_byte) begin
            mem_addr_q  <= word_idx_q[ADDR_W-1:0];
            mem_wdata_q <= word_next;
          end
        end
        S_WRITE: begin
          words_written <= words_written + CW'(1);
          if (!last_word) word_idx_q <= word_idx_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, stream gaps, length
// errors, ignored restart and mid-frame reset.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int ADDR_W = 11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            load_active;
  logic            done;
  logic            err_len;
  logic [ADDR_W:0] words_written;
  state_t          dbg_state;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(2048)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .bus           (bus),
    .load_active   (load_active),
    .done          (done),
    .err_len       (err_len),
    .words_written (words_written),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [7:0]  frame[$];
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0, done_cyc = 0, we_cyc = 0;
  int viol = 0, lat_err = 0, acc_cnt = 0;
  logic prev_acc = 1'b0;
  int d0, a0;

  // Monitor samples 1 time unit after the falling edge, when the inputs the
  // next rising edge will see are already settled.
  always begin
    @(negedge clk);
    #1;
    if (bus.mem_we) begin
      obs_q.push_back({21'b0, bus.mem_addr, bus.mem_wdata});
      we_cyc = cyc;
      if (bus.rx_ready) viol++;
      if (!prev_acc) lat_err++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_acc = bus.rx_valid && bus.rx_ready;
    if (prev_acc) acc_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [63:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      check(tag, o, e);
    end
    check({tag, "_extra"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("rx_ready_wait", bus.rx_ready, 1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input int maxgap);
    foreach (q[i]) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send_byte(q[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_load_active", load_active, 0);
    check("rst_done", done, 0);
    check("rst_err_len", err_len, 0);
    check("rst_words_written", words_written, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_state", dbg_state, S_IDLE);
    check("idle_load_active", load_active, 0);

    // basic two-word frame
    d0 = done_cnt; a0 = acc_cnt;
    pulse_start();
    check("f1_load_active", load_active, 1);
    check("f1_state", dbg_state, S_CNT_HI);
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    exp_q.push_back({21'b0, 11'd0, 32'h2008_0005});
    exp_q.push_back({21'b0, 11'd1, 32'hAC08_0000});
    send_bytes(frame, 0);
    repeat (4) @(negedge clk);
    check_writes("f1_write");
    check("f1_done_cnt", done_cnt - d0, 1);
    check("f1_done_lat", done_cyc - we_cyc, 1);
    check("f1_words_written", words_written, 2);
    check("f1_load_active_end", load_active, 0);
    check("f1_bytes", acc_cnt - a0, 10);

    // same frame with random gaps between bytes
    d0 = done_cnt; a0 = acc_cnt;
    pulse_start();
    exp_q.push_back({21'b0, 11'd0, 32'h2008_0005});
    exp_q.push_back({21'b0, 11'd1, 32'hAC08_0000});
    send_bytes(frame, 3);
    repeat (4) @(negedge clk);
    check_writes("f2_write");
    check("f2_done_cnt", done_cnt - d0, 1);
    check("f2_words_written", words_written, 2);
    check("f2_bytes", acc_cnt - a0, 10);

    // zero count
    d0 = done_cnt;
    pulse_start();
    frame = '{8'h00, 8'h00};
    send_bytes(frame, 0);
    check("f3_err_len", err_len, 1);
    check("f3_state", dbg_state, S_IDLE);
    check("f3_load_active", load_active, 0);
    check("f3_rx_ready", bus.rx_ready, 0);
    pulse_start();
    check("f3_err_clear", err_len, 0);
    // count 2049, one beyond the store
    frame = '{8'h08, 8'h01};
    send_bytes(frame, 0);
    check("f3b_err_len", err_len, 1);
    repeat (3) @(negedge clk);
    check_writes("f3_nowrite");
    check("f3_done_cnt", done_cnt - d0, 0);

    // start pulsed mid-DATA is ignored
    d0 = done_cnt;
    pulse_start();
    check("f4_err_clear", err_len, 0);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34};
    send_bytes(frame, 0);
    pulse_start();
    check("f4_state_kept", dbg_state, S_DATA);
    check("f4_load_active", load_active, 1);
    frame = '{8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    exp_q.push_back({21'b0, 11'd0, 32'h1234_5678});
    exp_q.push_back({21'b0, 11'd1, 32'h9ABC_DEF0});
    send_bytes(frame, 0);
    repeat (4) @(negedge clk);
    check_writes("f4_write");
    check("f4_done_cnt", done_cnt - d0, 1);
    check("f4_words_written", words_written, 2);

    // count 2048 accepted, then reset after 5 data bytes
    pulse_start();
    frame = '{8'h08, 8'h00};
    send_bytes(frame, 0);
    check("f5_max_state", dbg_state, S_DATA);
    check("f5_max_err", err_len, 0);
    frame = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_q.push_back({21'b0, 11'd0, 32'h1122_3344});
    send_bytes(frame, 0);
    check("f5_words_before_rst", words_written, 1);
    rst_n = 1'b0;
    #1;
    check("f5_rst_state", dbg_state, S_IDLE);
    check("f5_rst_load_active", load_active, 0);
    check("f5_rst_rx_ready", bus.rx_ready, 0);
    check("f5_rst_mem_addr", bus.mem_addr, 0);
    check("f5_rst_mem_wdata", bus.mem_wdata, 0);
    check("f5_rst_words", words_written, 0);
    check_writes("f5_partial");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    pulse_start();
    frame = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.push_back({21'b0, 11'd0, 32'hDEAD_BEEF});
    send_bytes(frame, 0);
    repeat (4) @(negedge clk);
    check_writes("f6_write");
    check("f6_done_cnt", done_cnt - d0, 1);
    check("f6_words_written", words_written, 1);
    check("f6_mem_hold", bus.mem_wdata, 32'hDEAD_BEEF);

    // stream-wide properties
    check("we_while_ready", viol, 0);
    check("write_latency", lat_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
